// File: rtl/mlp_layer_engine.sv
`timescale 1ns/1ps
// mlp_layer_engine: fully-connected layer over an N_IN-element signed input
// vector. Neurons are processed LANES at a time; each one gets a bias, an
// arithmetic right shift, saturation to DATA_W and an optional ReLU. The
// packed results and a one-hot argmax are held until the next run
// overwrites them. Inputs and weights are read from external synchronous
// memories with one cycle of read latency.
module mlp_layer_engine #(
    parameter int N_IN    = 62,
    parameter int N_OUT   = 10,
    parameter int LANES   = 2,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 20,
    parameter int SHIFT   = 0,
    localparam int G      = N_OUT / LANES,
    localparam int XAW    = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int WAW    = (G * (N_IN + 1) > 1) ? $clog2(G * (N_IN + 1)) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    relu_en,
    output logic [XAW-1:0]          x_addr,
    input  logic [DATA_W-1:0]       x_data,
    output logic [WAW-1:0]          w_addr,
    input  logic [LANES*DATA_W-1:0] w_data,
    output logic                    busy,
    output logic                    done,
    output logic [N_OUT*DATA_W-1:0] answer,
    output logic [N_OUT-1:0]        maxi
);

    localparam int KW = $clog2(N_IN + 1);
    localparam int GW = (G > 1) ? $clog2(G) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state;
    logic [KW-1:0]             k;
    logic [GW-1:0]             g;
    logic                      relu_l;

    logic signed [ACC_W-1:0]    acc     [LANES];
    logic signed [DATA_W-1:0]   ans_r   [N_OUT];

    logic signed [DATA_W-1:0]   w_lane  [LANES];
    logic signed [2*DATA_W-1:0] prod    [LANES];
    logic signed [ACC_W-1:0]    term    [LANES];
    logic signed [ACC_W-1:0]    shifted [LANES];
    logic signed [DATA_W-1:0]   sat     [LANES];

    logic signed [DATA_W-1:0]   best;
    logic [N_OUT-1:0]           maxi_next;

    // Addend for each lane: full-width product in RUN, bare bias in DRAIN
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            w_lane[j] = w_data[j*DATA_W +: DATA_W];
            prod[j]   = (2*DATA_W)'($signed(x_data)) * (2*DATA_W)'(w_lane[j]);
            if (state == S_DRAIN) begin
                term[j] = ACC_W'(w_lane[j]);
            end else begin
                term[j] = ACC_W'(prod[j]);
            end
        end
    end

    // Shift, saturate and optionally rectify each lane's accumulator
    always_comb begin
        for (int unsigned j = 0; j < LANES; j++) begin
            shifted[j] = acc[j] >>> SHIFT;
            if (shifted[j] > SAT_MAX) begin
                sat[j] = SAT_MAX[DATA_W-1:0];
            end else if (shifted[j] < SAT_MIN) begin
                sat[j] = SAT_MIN[DATA_W-1:0];
            end else begin
                sat[j] = shifted[j][DATA_W-1:0];
            end
            if (relu_l && shifted[j][ACC_W-1]) begin
                sat[j] = '0;
            end
        end
    end

    // Argmax over the stored answers; strict greater-than keeps the lowest index on ties
    always_comb begin
        best         = ans_r[0];
        maxi_next    = '0;
        maxi_next[0] = 1'b1;
        for (int unsigned n = 1; n < N_OUT; n++) begin
            if (ans_r[n] > best) begin
                best         = ans_r[n];
                maxi_next    = '0;
                maxi_next[n] = 1'b1;
            end
        end
    end

    // Pack the per-neuron results onto the answer bus
    always_comb begin
        answer = '0;
        for (int unsigned n = 0; n < N_OUT; n++) begin
            answer[n*DATA_W +: DATA_W] = ans_r[n];
        end
    end

    // Control FSM: address generation, accumulation, write-back and completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            maxi   <= '0;
            x_addr <= '0;
            w_addr <= '0;
            k      <= '0;
            g      <= '0;
            relu_l <= 1'b0;
            for (int unsigned j = 0; j < LANES; j++) begin
                acc[j] <= '0;
            end
            for (int unsigned n = 0; n < N_OUT; n++) begin
                ans_r[n] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        relu_l <= relu_en;
                        g      <= '0;
                        k      <= '0;
                        x_addr <= '0;
                        w_addr <= '0;
                        busy   <= 1'b1;
                        for (int unsigned j = 0; j < LANES; j++) begin
                            acc[j] <= '0;
                        end
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Data on the bus belongs to the address issued one cycle ago,
                    // so the k=0 cycle has nothing to consume yet.
                    if (k != '0) begin
                        for (int unsigned j = 0; j < LANES; j++) begin
                            acc[j] <= acc[j] + term[j];
                        end
                    end
                    if (k == KW'(N_IN)) begin
                        state <= S_DRAIN;
                    end else begin
                        k      <= k + KW'(1);
                        w_addr <= w_addr + WAW'(1);
                        x_addr <= (k < KW'(N_IN - 1)) ? XAW'(k + KW'(1)) : XAW'(N_IN - 1);
                    end
                end
                S_DRAIN: begin
                    for (int unsigned j = 0; j < LANES; j++) begin
                        acc[j] <= acc[j] + term[j];
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    for (int unsigned gi = 0; gi < G; gi++) begin
                        if (g == GW'(gi)) begin
                            for (int unsigned j = 0; j < LANES; j++) begin
                                ans_r[gi*LANES + j] <= sat[j];
                            end
                        end
                    end
                    for (int unsigned j = 0; j < LANES; j++) begin
                        acc[j] <= '0;
                    end
                    if (g == GW'(G - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        g      <= g + GW'(1);
                        k      <= '0;
                        x_addr <= '0;
                        w_addr <= w_addr + WAW'(1);
                        state  <= S_RUN;
                    end
                end
                S_DONE: begin
                    maxi  <= maxi_next;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_layer_engine.sv
`timescale 1ns/1ps
// tb_mlp_layer_engine: two engines (SHIFT=0 and SHIFT=2) share one stimulus
// stream; expected results from a neuron-level reference model are queued
// at start time and a monitor compares them whenever done pulses.
module tb_mlp_layer_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 4;
    localparam int LANES = 2;
    localparam int DW    = 8;
    localparam int AW    = 20;
    localparam int G     = N_OUT / LANES;
    localparam int NW    = G * (N_IN + 1);
    localparam int XAW   = 2;
    localparam int WAW   = 4;

    typedef struct packed {
        logic [N_OUT*DW-1:0] ans;
        logic [N_OUT-1:0]    maxi;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic relu_en = 1'b0;

    logic [XAW-1:0]       xa0, xa1;
    logic [WAW-1:0]       wa0, wa1;
    logic [DW-1:0]        xd0, xd1;
    logic [LANES*DW-1:0]  wd0, wd1;
    logic                 busy0, busy1, done0, done1;
    logic [N_OUT*DW-1:0]  ans0, ans1;
    logic [N_OUT-1:0]     maxi0, maxi1;

    logic [DW-1:0]        xmem [N_IN];
    logic [LANES*DW-1:0]  wmem [NW];

    int xv [N_IN];
    int wv [N_OUT][N_IN];
    int bv [N_OUT];

    exp_t q0 [$];
    exp_t q1 [$];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mlp_layer_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES),
        .DATA_W(DW), .ACC_W(AW), .SHIFT(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .x_addr(xa0), .x_data(xd0), .w_addr(wa0), .w_data(wd0),
        .busy(busy0), .done(done0), .answer(ans0), .maxi(maxi0)
    );

    mlp_layer_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES),
        .DATA_W(DW), .ACC_W(AW), .SHIFT(2)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start), .relu_en(relu_en),
        .x_addr(xa1), .x_data(xd1), .w_addr(wa1), .w_data(wd1),
        .busy(busy1), .done(done1), .answer(ans1), .maxi(maxi1)
    );

    // synchronous read memories, one cycle latency
    always @(posedge clk) begin
        xd0 <= xmem[xa0];
        wd0 <= wmem[wa0];
        xd1 <= xmem[xa1];
        wd1 <= wmem[wa1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: plain dot products over the neuron-level arrays
    function automatic exp_t model(input int shift, input logic relu);
        exp_t e;
        int   res [N_OUT];
        int   acc, r, best, bi;
        e = '0;
        for (int n = 0; n < N_OUT; n++) begin
            acc = bv[n];
            for (int kk = 0; kk < N_IN; kk++) acc += xv[kk] * wv[n][kk];
            acc = acc & ((1 << AW) - 1);
            if (acc >= (1 << (AW - 1))) acc = acc - (1 << AW);
            r = acc >>> shift;
            if (r > 127) r = 127;
            if (r < -128) r = -128;
            if (relu && r < 0) r = 0;
            res[n] = r;
            e.ans[n*DW +: DW] = DW'(r);
        end
        best = res[0];
        bi = 0;
        for (int n = 1; n < N_OUT; n++) begin
            if (res[n] > best) begin
                best = res[n];
                bi = n;
            end
        end
        e.maxi = N_OUT'(1) << bi;
        return e;
    endfunction

    task automatic load_mem();
        for (int kk = 0; kk < N_IN; kk++) xmem[kk] = DW'(xv[kk]);
        for (int gg = 0; gg < G; gg++) begin
            for (int kk = 0; kk <= N_IN; kk++) begin
                for (int j = 0; j < LANES; j++) begin
                    wmem[gg*(N_IN+1)+kk][j*DW +: DW] =
                        DW'((kk < N_IN) ? wv[gg*LANES+j][kk] : bv[gg*LANES+j]);
                end
            end
        end
    endtask

    task automatic push_expect(input logic relu);
        q0.push_back(model(0, relu));
        q1.push_back(model(2, relu));
    endtask

    task automatic set_all(input int x0, input int x1, input int x2, input int x3,
                           input int w, input int b);
        xv[0] = x0; xv[1] = x1; xv[2] = x2; xv[3] = x3;
        for (int n = 0; n < N_OUT; n++) begin
            bv[n] = b;
            for (int kk = 0; kk < N_IN; kk++) wv[n][kk] = w;
        end
    endtask

    // one run with latency/busy checks; optional start pulses at cycles pa/pb
    task automatic do_run(input logic relu, input int pa, input int pb);
        int dcyc, ndone, busy_bad;
        load_mem();
        push_expect(relu);
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        @(posedge clk);
        dcyc = -1; ndone = 0; busy_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            start = (c == pa || c == pb);
            relu_en = ~relu;
            if (done0) begin
                ndone++;
                if (dcyc < 0) dcyc = c;
            end
            if (busy0 !== (c >= 1 && c <= 14)) busy_bad++;
            @(posedge clk);
        end
        #1;
        chk("done_latency", 64'(dcyc), 64'd15);
        chk("done_count", 64'(ndone), 64'd1);
        chk("busy_window", 64'(busy_bad), 64'd0);
    endtask

    // scoreboard monitor
    initial begin : monitor
        exp_t e0, e1;
        logic p0, p1;
        logic [N_OUT-1:0] m0, m1;
        p0 = 1'b0; p1 = 1'b0; m0 = '0; m1 = '0;
        forever begin
            @(negedge clk);
            if (p0) begin chk("maxi_s0", 64'(maxi0), 64'(m0)); p0 = 1'b0; end
            if (p1) begin chk("maxi_s2", 64'(maxi1), 64'(m1)); p1 = 1'b0; end
            if (!rst && done0) begin
                chk("done_expected_s0", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) begin
                    e0 = q0.pop_front();
                    chk("answer_s0", 64'(ans0), 64'(e0.ans));
                    chk("busy_at_done_s0", 64'(busy0), 64'd0);
                    m0 = e0.maxi; p0 = 1'b1;
                end
            end
            if (!rst && done1) begin
                chk("done_expected_s2", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) begin
                    e1 = q1.pop_front();
                    chk("answer_s2", 64'(ans1), 64'(e1.ans));
                    m1 = e1.maxi; p1 = 1'b1;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nd, bad;
        set_all(0, 0, 0, 0, 0, 0);
        load_mem();
        #1;
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_done", 64'(done0), 64'd0);
        chk("reset_answer", 64'(ans0), 64'd0);
        chk("reset_maxi", 64'(maxi0), 64'd0);
        chk("reset_addr", 64'({xa0, wa0}), 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // all weights 1, bias 0 -> 10 each
        set_all(1, 2, 3, 4, 1, 0);
        do_run(1'b0, 0, 0);
        chk("t1_answer", 64'(ans0), 64'h0A0A0A0A);
        chk("t1_maxi", 64'(maxi0), 64'b0001);

        // neuron 2 stronger
        for (int kk = 0; kk < N_IN; kk++) wv[2][kk] = 2;
        bv[2] = 5;
        do_run(1'b0, 0, 0);
        chk("t2_answer", 64'(ans0), 64'h0A190A0A);
        chk("t2_maxi", 64'(maxi0), 64'b0100);

        // saturation
        set_all(127, 127, 127, 127, 127, 0);
        do_run(1'b0, 0, 0);
        chk("sat_pos", 64'(ans0), 64'h7F7F7F7F);
        set_all(127, 127, 127, 127, -128, 0);
        do_run(1'b0, 0, 0);
        chk("sat_neg", 64'(ans0), 64'h80808080);
        do_run(1'b1, 0, 0);
        chk("sat_neg_relu", 64'(ans0), 64'h00000000);

        // small negative results, shifted and rectified
        set_all(1, 2, 3, 4, 1, -13);
        do_run(1'b1, 0, 0);
        chk("neg_relu_s2", 64'(ans1), 64'h00000000);
        chk("neg_relu_maxi_s2", 64'(maxi1), 64'b0001);
        do_run(1'b0, 0, 0);
        chk("neg_s0", 64'(ans0), 64'hFDFDFDFD);
        chk("neg_s2", 64'(ans1), 64'hFFFFFFFF);

        // start pulses while busy are ignored
        set_all(3, -1, 2, 5, 2, 7);
        wv[1][0] = -4; bv[3] = -20;
        do_run(1'b0, 3, 10);

        // start held high: back-to-back runs
        set_all(-2, 4, 1, 6, 3, 1);
        wv[0][3] = -5; wv[3][1] = 9;
        load_mem();
        push_expect(1'b1); push_expect(1'b1); push_expect(1'b1);
        @(negedge clk);
        start = 1'b1; relu_en = 1'b1;
        @(posedge clk);
        nd = 0; bad = 0;
        for (int c = 1; c <= 60; c++) begin
            #1;
            if (done0) begin
                nd++;
                if (c != 16 * nd - 1) bad++;
                if (nd == 3) start = 1'b0;
            end
            @(posedge clk);
        end
        start = 1'b0;
        chk("b2b_count", 64'(nd), 64'd3);
        chk("b2b_spacing", 64'(bad), 64'd0);

        // reset mid-run aborts
        load_mem();
        push_expect(1'b0);
        @(negedge clk);
        start = 1'b1; relu_en = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        q0.delete(); q1.delete();
        #1;
        chk("abort_busy", 64'(busy0), 64'd0);
        chk("abort_done", 64'(done0), 64'd0);
        chk("abort_answer", 64'(ans0), 64'd0);
        chk("abort_maxi", 64'(maxi0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done0 || done1) nd++;
        end
        chk("abort_no_done", 64'(nd), 64'd0);
        set_all(1, 2, 3, 4, 1, 0);
        do_run(1'b0, 0, 0);
        chk("after_abort_answer", 64'(ans0), 64'h0A0A0A0A);

        // randomized runs
        for (int r = 0; r < 16; r++) begin
            for (int kk = 0; kk < N_IN; kk++)
                xv[kk] = (r % 2) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
            for (int n = 0; n < N_OUT; n++) begin
                bv[n] = int'($urandom_range(0, 127)) - 64;
                for (int kk = 0; kk < N_IN; kk++)
                    wv[n][kk] = (r % 2) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
            end
            do_run(1'($urandom_range(0, 1)), 0, 0);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty_s0", 64'(q0.size()), 64'd0);
        chk("queue_empty_s2", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
